// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detector and EX operand-forwarding select generator for a 5-stage core.
// Build option FORWARDING_EN: when undefined, forwarding is off and every RAW hazard stalls.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  // In-flight instruction slots, shifted EX -> MEM -> WB every cycle
  logic                  ex_valid_reg,    mem_valid_reg,    wb_valid_reg;
  logic [REG_ADDR_W-1:0] ex_dest_reg,     mem_dest_reg,     wb_dest_reg;
  logic                  ex_wb_en_reg,    mem_wb_en_reg,    wb_wb_en_reg;
  logic                  ex_mem_read_reg, mem_mem_read_reg, wb_mem_read_reg;

  logic [CNT_W-1:0]      stall_cnt_reg;

  logic [REG_ADDR_W-1:0] id_src [2];
  logic [1:0]            id_use;
  logic [1:0]            hit_ex;
  logic [1:0]            hit_mem;
  logic                  stall_req;
  logic                  ex_load;

  assign id_src[0] = id_src1;
  assign id_src[1] = id_src2;
  assign id_use[0] = id_use1;
  assign id_use[1] = id_use2;

  // Producer match per source operand; register 0 is hard-wired and never matches
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic src_live;
      assign src_live    = id_use[gi] && (id_src[gi] != '0);
      assign hit_ex[gi]  = src_live && ex_valid_reg  && ex_wb_en_reg  &&
                           (ex_dest_reg  == id_src[gi]);
      assign hit_mem[gi] = src_live && mem_valid_reg && mem_wb_en_reg &&
                           (mem_dest_reg == id_src[gi]);
    end
  endgenerate

  assign ex_load = ex_mem_read_reg;

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time
  assign stall_req = (|hit_ex) && ex_load;
`else
  assign stall_req = (|hit_ex) || (|hit_mem);
`endif

  // A taken branch squashes the stalled instruction anyway, so flush wins
  assign flush = ex_branch_taken;
  assign stall = stall_req && !flush;

  logic ex_enter;
  assign ex_enter = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_reg     <= 1'b0;
      ex_dest_reg      <= '0;
      ex_wb_en_reg     <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      mem_valid_reg    <= 1'b0;
      mem_dest_reg     <= '0;
      mem_wb_en_reg    <= 1'b0;
      mem_mem_read_reg <= 1'b0;
      wb_valid_reg     <= 1'b0;
      wb_dest_reg      <= '0;
      wb_wb_en_reg     <= 1'b0;
      wb_mem_read_reg  <= 1'b0;
    end else begin
      wb_valid_reg     <= mem_valid_reg;
      wb_dest_reg      <= mem_dest_reg;
      wb_wb_en_reg     <= mem_wb_en_reg;
      wb_mem_read_reg  <= mem_mem_read_reg;
      mem_valid_reg    <= ex_valid_reg;
      mem_dest_reg     <= ex_dest_reg;
      mem_wb_en_reg    <= ex_wb_en_reg;
      mem_mem_read_reg <= ex_mem_read_reg;
      ex_valid_reg     <= ex_enter;
      ex_dest_reg      <= id_dest;
      ex_wb_en_reg     <= id_wb_en;
      ex_mem_read_reg  <= id_mem_read;
    end
  end

  // WB retires into a write-before-read register file, so it never forwards
  logic wb_slot_unused;
  assign wb_slot_unused = ^{wb_valid_reg, wb_dest_reg, wb_wb_en_reg, wb_mem_read_reg};

`ifdef FORWARDING_EN
  logic [1:0] sel_next [2];
  logic [1:0] fwd_sel_a_reg;
  logic [1:0] fwd_sel_b_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sel
      assign sel_next[gi] = (hit_ex[gi] && !ex_load) ? 2'd1 :
                            hit_mem[gi]              ? 2'd2 : 2'd0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_sel_a_reg <= 2'd0;
      fwd_sel_b_reg <= 2'd0;
    end else if (ex_enter) begin
      fwd_sel_a_reg <= sel_next[0];
      fwd_sel_b_reg <= sel_next[1];
    end else begin
      fwd_sel_a_reg <= 2'd0;
      fwd_sel_b_reg <= 2'd0;
    end
  end

  assign fwd_sel_a = fwd_sel_a_reg;
  assign fwd_sel_b = fwd_sel_b_reg;
`else
  assign fwd_sel_a = 2'd0;
  assign fwd_sel_b = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed hazard scenarios, async reset, random traffic.
module tb_hazard_fwd_unit;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src1 = '0;
  logic [AW-1:0] id_src2 = '0;
  logic          id_use1 = 1'b0;
  logic          id_use2 = 1'b0;
  logic [AW-1:0] id_dest = '0;
  logic          id_wb_en = 1'b0;
  logic          id_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          stall;
  logic          flush;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  // Reference model: instructions listed by age (index 0 = issued last cycle)
  typedef struct {
    bit          v;
    bit [AW-1:0] d;
    bit          wb;
    bit          mr;
  } ins_t;

  ins_t hist[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_stall;
  bit [1:0] m_sa, m_sb, m_fa, m_fb;
  int   m_cnt;
  int   cnt0;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ins_t b;
    b = '{v: 1'b0, d: '0, wb: 1'b0, mr: 1'b0};
    hist = {};
    hist.push_back(b);
    hist.push_back(b);
    m_fa = 2'd0;
    m_fb = 2'd0;
    m_cnt = 0;
  endtask

  // Age of the youngest in-flight writer of s: 1 = one instruction ahead, 2 = two ahead
  function automatic int age_of(bit [AW-1:0] s, bit use_s);
    if (!use_s || s == 0) return 0;
    for (int a = 0; a < 2; a++)
      if (hist[a].v && hist[a].wb && hist[a].d == s) return a + 1;
    return 0;
  endfunction

  task automatic model_comb();
    int  a1, a2;
    bit  hz;
    a1 = age_of(id_src1, id_use1);
    a2 = age_of(id_src2, id_use2);
`ifdef FORWARDING_EN
    hz   = ((a1 == 1) || (a2 == 1)) && hist[0].mr;
    m_sa = (a1 == 1) ? 2'd1 : (a1 == 2) ? 2'd2 : 2'd0;
    m_sb = (a2 == 1) ? 2'd1 : (a2 == 2) ? 2'd2 : 2'd0;
`else
    hz   = (a1 != 0) || (a2 != 0);
    m_sa = 2'd0;
    m_sb = 2'd0;
`endif
    m_stall = hz && !ex_branch_taken;
  endtask

  task automatic drv(bit v, bit [AW-1:0] s1, bit u1, bit [AW-1:0] s2, bit u2,
                     bit [AW-1:0] d, bit wb, bit mr, bit br);
    id_valid = v;  id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_dest = d;   id_wb_en = wb; id_mem_read = mr; ex_branch_taken = br;
  endtask

  // One clock cycle with the currently driven ID inputs; entered from posedge+1
  task automatic cyc(string tag);
    bit   enter;
    ins_t n;
    model_comb();
    @(negedge clk);
    chk({tag, ".stall"}, 16'(stall), 16'(m_stall));
    chk({tag, ".flush"}, 16'(flush), 16'(ex_branch_taken));
    enter = id_valid && !m_stall && !ex_branch_taken;
    n = '{v: enter, d: id_dest, wb: id_wb_en, mr: id_mem_read};
    @(posedge clk);
    #1;
    hist.push_front(n);
    void'(hist.pop_back());
    if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    m_fa = enter ? m_sa : 2'd0;
    m_fb = enter ? m_sb : 2'd0;
    chk({tag, ".fwd_a"}, 16'(fwd_sel_a), 16'(m_fa));
    chk({tag, ".fwd_b"}, 16'(fwd_sel_b), 16'(m_fb));
    chk({tag, ".cnt"}, 16'(stall_cnt), 16'(m_cnt));
    $display("%-10s v=%0b s1=%0d/%0b s2=%0d/%0b d=%0d wb=%0b mr=%0b br=%0b | stall=%0b fa=%0d fb=%0d cnt=%0d",
             tag, id_valid, id_src1, id_use1, id_src2, id_use2, id_dest, id_wb_en,
             id_mem_read, ex_branch_taken, m_stall, fwd_sel_a, fwd_sel_b, stall_cnt);
  endtask

  task automatic op(string tag, bit v, bit [AW-1:0] s1, bit u1, bit [AW-1:0] s2, bit u2,
                    bit [AW-1:0] d, bit wb, bit mr, bit br);
    drv(v, s1, u1, s2, u2, d, wb, mr, br);
    cyc(tag);
  endtask

  // Hold an instruction in ID until it leaves (stall released)
  task automatic issue(string tag, bit [AW-1:0] s1, bit u1, bit [AW-1:0] s2, bit u2,
                       bit [AW-1:0] d, bit wb, bit mr);
    for (int k = 0; k < 4; k++) begin
      op(tag, 1'b1, s1, u1, s2, u2, d, wb, mr, 1'b0);
      if (!m_stall) break;
    end
  endtask

  task automatic nops(int n);
    for (int k = 0; k < n; k++) op("nop", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 16'(stall), 16'(0));
    chk("rst.fwd_a", 16'(fwd_sel_a), 16'(0));
    chk("rst.fwd_b", 16'(fwd_sel_b), 16'(0));
    chk("rst.cnt", 16'(stall_cnt), 16'(0));
    ex_branch_taken = 1'b1;
    #1;
    chk("rst.flush", 16'(flush), 16'(1));
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD r1 ; ADD r2,r1,r3
    op("add_r1", 1, 2, 1, 3, 1, 1, 1, 0, 0);
    issue("add_r2", 1, 1, 3, 1, 2, 1, 0);
`ifdef FORWARDING_EN
    chk("b2b.fwd_a", 16'(fwd_sel_a), 16'(1));
`endif
    nops(2);

    // ADD r1 ; NOP ; SUB r4,r5,r1
    op("add_r1", 1, 2, 1, 3, 1, 1, 1, 0, 0);
    nops(1);
    issue("sub_r4", 5, 1, 1, 1, 4, 1, 0);
`ifdef FORWARDING_EN
    chk("gap.fwd_a", 16'(fwd_sel_a), 16'(0));
    chk("gap.fwd_b", 16'(fwd_sel_b), 16'(2));
`endif
    nops(2);

    // LW r2 ; ADD r3,r2,r2
    cnt0 = m_cnt;
    op("lw_r2", 1, 4, 1, 0, 0, 2, 1, 1, 0);
    issue("add_r3", 2, 1, 2, 1, 3, 1, 0);
`ifdef FORWARDING_EN
    chk("ldu.cnt", 16'(stall_cnt), 16'(cnt0 + 1));
    chk("ldu.fwd_a", 16'(fwd_sel_a), 16'(2));
    chk("ldu.fwd_b", 16'(fwd_sel_b), 16'(2));
`else
    chk("ldu.cnt", 16'(stall_cnt), 16'(cnt0 + 2));
`endif
    nops(2);

    // ADD r0 ; ADD r1,r0,r0
    op("add_r0", 1, 1, 1, 2, 1, 0, 1, 0, 0);
    op("use_r0", 1, 0, 1, 0, 1, 1, 1, 0, 0);
    chk("r0.stall", 16'(stall), 16'(0));
    chk("r0.fwd_a", 16'(fwd_sel_a), 16'(0));
    chk("r0.fwd_b", 16'(fwd_sel_b), 16'(0));
    nops(2);

    // Load-use hazard coinciding with a taken branch
    op("lw_r2", 1, 4, 1, 0, 0, 2, 1, 1, 0);
    op("br_ldu", 1, 2, 1, 2, 1, 3, 1, 0, 1);
    chk("brl.fwd_a", 16'(fwd_sel_a), 16'(0));
    nops(2);

    // ADD r1 ; ADD r2,r1,r1
    cnt0 = m_cnt;
    op("add_r1", 1, 2, 1, 3, 1, 1, 1, 0, 0);
    issue("add_r2", 1, 1, 1, 1, 2, 1, 0);
`ifndef FORWARDING_EN
    chk("nofwd.cnt", 16'(stall_cnt), 16'(cnt0 + 2));
`else
    chk("fwd.cnt", 16'(stall_cnt), 16'(cnt0));
`endif
    nops(2);

    // Async reset while a load-use stall is active
    op("lw_r1", 1, 4, 1, 0, 0, 1, 1, 1, 0);
    drv(1, 1, 1, 1, 1, 2, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst.stall", 16'(stall), 16'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst.stall", 16'(stall), 16'(0));
    chk("mid_rst.fwd_a", 16'(fwd_sel_a), 16'(0));
    chk("mid_rst.fwd_b", 16'(fwd_sel_b), 16'(0));
    chk("mid_rst.cnt", 16'(stall_cnt), 16'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    nops(1);

    // Random traffic, enough stalls to saturate the narrow counter
    for (int i = 0; i < 300; i++) begin
      bit wb;
      wb = $urandom_range(0, 3) != 0;
      drv($urandom_range(0, 7) != 0, AW'($urandom), 1'($urandom), AW'($urandom), 1'($urandom),
          AW'($urandom), wb, wb && ($urandom_range(0, 2) == 0), $urandom_range(0, 7) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
